// File: rtl/async_fifo_rd_drain.sv
// Read-side master for the asynchronous FIFO: issues reads while data is available,
// captures the returned words into a 2-entry buffer and presents them on a valid/ready stream.
module async_fifo_rd_drain #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             empty_i,
    input  logic             rd_error_i,
    input  logic [WIDTH-1:0] rdata_i,
    output logic             rd_en_o,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i,
    output logic [CNT_W-1:0] rd_count_o,
    output logic [7:0]       err_count_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       occ;
    logic             pend;
    logic [WIDTH-1:0] tail;
    logic             pop;
    logic             push;
    logic [2:0]       committed;

    assign pop       = m_valid_o & m_ready_i;
    assign push      = pend & ~rd_error_i;
    assign m_valid_o = (occ != 2'd0);

    // Slots already spoken for after this cycle: buffered words plus the one in flight,
    // less the word leaving now. A read is only issued if it is guaranteed a slot.
    assign committed = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
    assign rd_en_o   = (state == RUN) & ~empty_i & (committed < 3'd2);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
        end else begin
            busy_o <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (enable_i) state <= RUN;
                end
                RUN: begin
                    if (!enable_i) state <= DRAIN;
                end
                DRAIN: begin
                    if (enable_i) begin
                        state <= RUN;
                    end else if (!pend && (occ == 2'd0)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // m_data_o is the head slot and tail the second slot; a pop shifts tail into head.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ         <= 2'd0;
            pend        <= 1'b0;
            tail        <= '0;
            m_data_o    <= '0;
            rd_count_o  <= '0;
            err_count_o <= 8'd0;
        end else begin
            pend <= rd_en_o;

            if (pop) begin
                rd_count_o <= rd_count_o + CNT_W'(1);
            end

            if (pend && rd_error_i && (err_count_o != 8'hFF)) begin
                err_count_o <= err_count_o + 8'd1;
            end

            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        m_data_o <= rdata_i;
                    end else begin
                        tail <= rdata_i;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd2) begin
                        m_data_o <= tail;
                    end
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd2) begin
                        m_data_o <= tail;
                        tail     <= rdata_i;
                    end else begin
                        m_data_o <= rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
